// File: rtl/nco_sincos.sv
// Quadrature NCO: 32-bit phase accumulator, quarter-wave sine table, 13-bit signed sin/cos outputs.
// Ports: clk, reset_n (sync, active-low), clken (global hold), phi_inc_i (phase step),
//        fsin_o/fcos_o (two's complement, +/-4095), out_valid (pipeline primed since reset).
// Latency 3 enabled edges from accumulator to output; clken low freezes every register.
// Optional build macro NCO_ROUND_EN: round the phase to the nearest table address instead of truncating.
module nco_sincos (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clken,
  input  logic [31:0] phi_inc_i,
  output logic [12:0] fsin_o,
  output logic [12:0] fcos_o,
  output logic        out_valid
);

  // pi in Q60: hex expansion of pi is 3.243F6A8885A308D...
  localparam logic [127:0] PI_Q60 = 128'h3243F6A8885A308D;

  // Elaboration-time table entry: round(4095*sin(pi*k/2048)) via a Q60 Taylor series.
  // Positive and negative terms are summed separately so everything stays unsigned.
  function automatic logic [11:0] quarter_sine(input int k);
    logic [127:0] x, x2, term, pos, neg, val;
    x    = (PI_Q60 * 128'(k)) >> 11;
    x2   = (x * x) >> 60;
    term = x;
    pos  = x;
    neg  = '0;
    for (int n = 1; n < 16; n++) begin
      term = (term * x2) >> 60;
      term = term / 128'((2 * n) * (2 * n + 1));
      if ((n % 2) == 1) neg = neg + term;
      else              pos = pos + term;
    end
    val = ((pos - neg) * 128'd4095 + (128'd1 << 59)) >> 60;
    return 12'(val);
  endfunction

  logic [11:0] rom [0:1024];

  for (genvar k = 0; k <= 1024; k++) begin : g_rom
    localparam logic [11:0] VAL = quarter_sine(k);
    assign rom[k] = VAL;
  end

  logic [31:0] acc;
  logic [11:0] addr;
  logic [11:0] addr_q;
  logic [11:0] cos_addr;
  logic [10:0] sin_idx;
  logic [10:0] cos_idx;
  logic [11:0] sin_mag;
  logic [11:0] cos_mag;
  logic        sin_neg;
  logic        cos_neg;
  logic [1:0]  cnt;

  always_comb begin
`ifdef NCO_ROUND_EN
    addr = acc[31:20] + {11'd0, acc[19]};
`else
    addr = acc[31:20];
`endif
  end

  // Cosine is the sine a quarter turn ahead. Odd quadrants read the table mirrored
  // (1024 - i); the upper half of the circle only flips the sign.
  always_comb begin
    cos_addr = addr_q + 12'd1024;
    sin_idx  = addr_q[10]   ? (11'd1024 - {1'b0, addr_q[9:0]})   : {1'b0, addr_q[9:0]};
    cos_idx  = cos_addr[10] ? (11'd1024 - {1'b0, cos_addr[9:0]}) : {1'b0, cos_addr[9:0]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc     <= '0;
      addr_q  <= '0;
      sin_mag <= '0;
      cos_mag <= '0;
      sin_neg <= 1'b0;
      cos_neg <= 1'b0;
      fsin_o  <= '0;
      fcos_o  <= '0;
      cnt     <= '0;
    end else if (clken) begin
      acc     <= acc + phi_inc_i;
      addr_q  <= addr;
      sin_mag <= rom[sin_idx];
      cos_mag <= rom[cos_idx];
      sin_neg <= addr_q[11];
      cos_neg <= cos_addr[11];
      // Negating a zero magnitude yields zero, so no special case for -0.
      fsin_o  <= sin_neg ? -{1'b0, sin_mag} : {1'b0, sin_mag};
      fcos_o  <= cos_neg ? -{1'b0, cos_mag} : {1'b0, cos_mag};
      if (cnt != 2'd3) cnt <= cnt + 2'd1;
    end
  end

  assign out_valid = (cnt == 2'd3);

endmodule

// File: tb/tb_nco_sincos.sv
module tb_nco_sincos;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clken = 1'b0;
  logic [31:0] phi_inc = '0;
  logic [12:0] fsin;
  logic [12:0] fcos;
  logic        out_valid;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;
  int en_edges = 0;

  localparam real PI = 3.14159265358979323846;

  nco_sincos dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clken     (clken),
    .phi_inc_i (phi_inc),
    .fsin_o    (fsin),
    .fcos_o    (fcos),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Ideal oscillator value at the quantised phase address.
  function automatic int model_val(input logic [31:0] ph, input bit cosine);
    logic [11:0] a;
    real r;
    int mag;
    a = ph[31:20];
`ifdef NCO_ROUND_EN
    a = ph[31:20] + {11'd0, ph[19]};
`endif
    r = 4095.0 * (cosine ? $cos(2.0 * PI * a / 4096.0) : $sin(2.0 * PI * a / 4096.0));
    mag = $rtoi(((r < 0.0) ? -r : r) + 0.5);
    return (r < 0.0) ? -mag : mag;
  endfunction

  // Count of enabled cycles since reset; sample n = en_edges-3 has phase n*phi.
  always @(posedge clk) begin
    if (!reset_n) en_edges = 0;
    else if (clken) en_edges = en_edges + 1;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      int s, c, es, ec;
      logic [31:0] ph;
      tests++;
      if (out_valid !== (en_edges >= 3)) begin
        fails++;
        $display("FAIL model_valid: got %0b expected %0b (edges %0d)", out_valid, en_edges >= 3, en_edges);
      end
      if (en_edges >= 3) begin
        ph = 32'(en_edges - 3) * phi_inc;
        s  = $signed(fsin);
        c  = $signed(fcos);
        es = model_val(ph, 1'b0);
        ec = model_val(ph, 1'b1);
        tests++;
        if (s != es || c != ec) begin
          fails++;
          $display("FAIL model_sample: phase %h got sin %0d cos %0d expected sin %0d cos %0d", ph, s, c, es, ec);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_sample(input string nm, input int es, input int ec);
    chk({nm, "_valid"}, int'(out_valid), 1);
    chk({nm, "_sin"}, $signed(fsin), es);
    chk({nm, "_cos"}, $signed(fcos), ec);
  endtask

  task automatic restart(input logic [31:0] phi);
    reset_n = 1'b0;
    edges(1);
    phi_inc = phi;
    reset_n = 1'b1;
  endtask

  int sp[4] = '{0, 4095, 0, -4095};
  int cp[4] = '{4095, 0, -4095, 0};

  initial begin
    clken   = 1'b1;
    reset_n = 1'b0;
    phi_inc = 32'h028F5C29;
    edges(3);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_sin", $signed(fsin), 0);
    chk("rst_cos", $signed(fcos), 0);
    chk_on  = 1'b1;
    reset_n = 1'b1;

    edges(2);
    chk("fill_valid", int'(out_valid), 0);
    edges(1);
    chk_sample("s0", 0, 4095);
    edges(25);
    chk_sample("s25", 4095, 0);
    edges(25);
    chk_sample("s50", 0, -4095);

    restart(32'h40000000);
    edges(3);
    for (int m = 0; m < 8; m++) begin
      if (m > 0) edges(1);
      chk_sample("quad", sp[m % 4], cp[m % 4]);
    end
    clken = 1'b0;
    for (int m = 0; m < 5; m++) begin
      edges(1);
      chk_sample("hold", sp[3], cp[3]);
    end
    clken = 1'b1;
    edges(1);
    chk_sample("resume", sp[0], cp[0]);
    edges(1);
    chk_sample("resume1", sp[1], cp[1]);

    reset_n = 1'b0;
    edges(1);
    chk("pulse_valid", int'(out_valid), 0);
    chk("pulse_sin", $signed(fsin), 0);
    chk("pulse_cos", $signed(fcos), 0);
    reset_n = 1'b1;
    edges(2);
    chk("pulse_fill", int'(out_valid), 0);
    edges(1);
    chk_sample("pulse_s0", 0, 4095);

    restart(32'h00000000);
    edges(8);
    chk_sample("phi0", 0, 4095);

    restart(32'h00080000);
    edges(3);
    chk_sample("rnd_s0", 0, 4095);
    edges(1);
`ifdef NCO_ROUND_EN
    chk_sample("rnd_s1", 6, 4095);
`else
    chk_sample("rnd_s1", 0, 4095);
`endif

    restart(32'h01234567);
    edges(300);
    restart(32'h9E3779B9);
    edges(300);
    restart(32'hFFFFFFFF);
    edges(20);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nco_sincos.md
# nco_sincos

Numerically controlled oscillator producing quadrature sine and cosine samples from a 32-bit phase-increment word. It is used as the local-oscillator source in the modulation datapath and drives 13-bit two's-complement I/Q samples into downstream mixers/DACs. The block contains a phase accumulator, a quarter-wave amplitude table, and a 3-stage output pipeline gated by a clock enable.

## Interface
- No parameters. Widths are fixed: phase 32 bits, table address 12 bits, amplitude 13 bits.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- clken  in  1  clock enable; when low, every register holds its value.
- phi_inc_i  in  32  unsigned phase increment per enabled cycle; f_out = phi_inc_i·f_clk/2^32.
- fsin_o  out  13  sine sample, two's complement, range −4095..+4095.
- fcos_o  out  13  cosine sample, two's complement, range −4095..+4095.
- out_valid  out  1  high when fsin_o/fcos_o carry a valid sample.

## Operation
- Accumulator acc[31:0]: on each enabled edge, acc <= acc + phi_inc_i, modulo 2^32 (wraps silently).
- Address a[11:0] = acc[31:20], or the rounded value when NCO_ROUND_EN is set; see Configuration.
- Table S(k), k = 0..1024 (1025 entries): S(k) = round(4095·sin(π·k/2048)), unsigned 12-bit. S(0) = 0; S(1024) = 4095.
- Sine of address a: q = a[11:10], i = a[9:0].
  - q=0: +S(i)
  - q=1: +S(1024−i)
  - q=2: −S(i)
  - q=3: −S(1024−i)
- Cosine of address a is the sine of (a + 1024) mod 4096.
- Negation is two's complement at 13 bits; −0 = 0.
- Pipeline, all stages advancing only when clken = 1:
  - Stage 1 registers the address derived from acc before the increment.
  - Stage 2 registers the table magnitudes and sign bits for sine and cosine.
  - Stage 3 registers the signed fsin_o/fcos_o.
- Sample n (the n-th cycle with out_valid = 1, n from 0) corresponds to phase n·phi_inc_i mod 2^32, provided phi_inc_i is held constant.
- out_valid comes from a 2-bit saturating counter of enabled cycles since reset. It asserts once the counter reaches 3 and stays high until the next reset.

## Timing
- Reset (reset_n = 0 at a rising edge) clears acc, all pipeline registers, the counter, fsin_o, fcos_o and out_valid to 0. This takes priority over clken and applies mid-operation with the same result.
- Latency: 3 enabled edges from acc value to output.
  - out_valid rises on the 3rd enabled edge after reset deasserts, carrying the phase-0 sample (sin 0, cos 4095).
  - One new sample follows per enabled edge after that.
- clken low for N cycles: outputs, out_valid and acc are frozen. The sequence resumes unchanged, with no skipped or duplicated samples.
- A change to phi_inc_i is sampled at the next enabled edge. It first affects the sample 2 positions after the one currently in stage 1.

## Configuration
- NCO_ROUND_EN defined:
  - a = (acc[31:20] + acc[19]) mod 4096, i.e. round-to-nearest phase quantisation, wrapping at 4096.
- NCO_ROUND_EN undefined:
  - a = acc[31:20], i.e. truncation.
- Latency and all other behaviour are identical in both builds.

## Test plan
- Reset release, phi_inc_i = 0x028F5C29, clken = 1 → out_valid is low for 2 edges and high from the 3rd. Expected samples:
  - sample 0: sin 0, cos 4095
  - sample 25 (phase 0x40000001): sin 4095, cos 0
  - sample 50: sin 0, cos −4095 (0x1001)
- phi_inc_i = 0x40000000 → sin repeats 0, 4095, 0, −4095 and cos repeats 4095, 0, −4095, 0. Output stays within ±4095.
- phi_inc_i = 0 → every sample is sin 0, cos 4095.
- clken low for 5 cycles mid-stream (phi 0x40000000) → outputs and out_valid hold. After clken returns, the next sample continues the 4-cycle pattern with no gap.
- reset_n pulsed low for 1 cycle mid-stream → all outputs 0 and out_valid 0 on that edge. The sequence restarts at the phase-0 sample 3 enabled edges later.
- phi_inc_i = 0x00080000, sample 1 (acc 0x00080000):
  - with NCO_ROUND_EN: sin 6, cos 4095
  - without NCO_ROUND_EN: sin 0, cos 4095
